input_mat_loader: RTL and testbench
===================================

Name: input_mat_loader

Overview:
- Upstream controller for the 8x8 input-matrix register bank.
- On a start pulse it reads one 8x8 matrix of 8-bit elements from on-chip RAM as 16 words of 4 elements each.
- It drives the register bank's enable, bank_select_line, select_line and data_in, with the select lines timed to match the bank's internal select-delay pipeline.
- It signals done once every word has settled into the bank.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- BANK_DEPTH, 8, matrix dimension (rows = banks, elements per bank).
- ADDR_WIDTH, 10, RAM word-address width.
- RAM_LATENCY, 1, cycles from ram_en/ram_addr to valid ram_rdata; legal range 1..4.
- SEL_LEAD, 2, cycles by which select lines lead mat_data_in; must satisfy SEL_LEAD <= RAM_LATENCY+1.
- FLUSH_CYCLES, 3, cycles mat_enable stays high after the last data word so the downstream delayed selects complete.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle load request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  RAM word address of matrix word 0; sampled with start.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the load is complete.
- ram_en  out  1  RAM read strobe.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_rdata  in  4*DATA_WIDTH  RAM read data, valid RAM_LATENCY cycles after ram_en.
- mat_enable  out  1  register-bank enable.
- mat_bank_sel  out  3  bank_select_line (matrix row).
- mat_sel  out  3  select_line; 0 = elements 0-3, 1 = elements 4-7; bits [2:1] always 0.
- mat_data_in  out  4*DATA_WIDTH  register-bank data_in.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; issue counter, tag pipeline and data register cleared. Reset mid-load aborts the load immediately; no done is produced.
- FSM states: IDLE -> ISSUE -> DRAIN -> FLUSH -> DONE -> IDLE.
- IDLE:
  - start=1 latches base_addr, clears word counter k, sets busy, goes to ISSUE.
  - start in any other state is ignored.
- ISSUE, 16 cycles, k = 0..15:
  - ram_en=1, ram_addr = base_addr + k; wraps modulo 2^ADDR_WIDTH.
  - Tag {valid, bank=k>>1, half=k&1} enters a tag shift register of depth RAM_LATENCY+1.
  - After k=15 goes to DRAIN.
- Data path:
  - When the tag reaches stage RAM_LATENCY, ram_rdata is registered into mat_data_in.
  - Word k is therefore presented at issue cycle + RAM_LATENCY + 1.
  - mat_data_in holds its last value when no valid tag is present.
- Select path:
  - mat_bank_sel/mat_sel are registered from tag stage RAM_LATENCY+1-SEL_LEAD, i.e. SEL_LEAD cycles before the matching mat_data_in.
  - When no valid tag is present they hold their last value.
- DRAIN: waits until the tag pipeline is empty (last data word presented), then goes to FLUSH.
- FLUSH: counts FLUSH_CYCLES cycles, then goes to DONE.
- DONE: done=1 for one cycle, busy deasserts in the same cycle, returns to IDLE.
- mat_enable equals busy; it is high continuously from the first ISSUE cycle through the DONE cycle, so downstream delay registers advance every cycle.
- Timing with defaults (start accepted at cycle 0):
  - ram_addr words at cycles 1..16.
  - mat_data_in words at cycles 3..18.
  - selects at cycles 1..16.
  - done at cycle 22.
- Word ordering: bank b receives its elements 0-3 then 4-7 (words 2b, 2b+1).

Optional Feature:
- Macro LOAD_CNT_EN.
- Defined: adds output load_count [15:0]. It increments on each done pulse, wraps 0xFFFF->0, and clears on reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package holds: DATA_WIDTH, BANK_DEPTH, SELECT_WIDTH=3, WORDS_PER_MATRIX=16, the FSM state enum, and the tag struct {valid, bank[2:0], half}.
- One natural sub-module: input_mat_tag_pipe, a parameterised-depth shift register of tags with tap outputs at the data stage and the select stage.

Test Plan:
- Defaults, base_addr=0x040, RAM word n = {4{n[7:0]}} -> ram_addr 0x040..0x04F at cycles 1..16; mat_data_in word k at cycle 3+k; matching bank_sel/sel at cycle 1+k; done at cycle 22; busy cycles 1..22.
- Pass-through into the real register bank -> after done, data_out[b] = {w(2b+1), w(2b)} for b = 0..7.
- base_addr=0x3F8, ADDR_WIDTH=10 -> addresses 0x3F8..0x3FF then wrap to 0x000..0x007.
- start pulsed again at cycles 5 and 22 -> both ignored; no second load; exactly one done.
- reset asserted at cycle 10 -> all outputs 0 next edge, FSM IDLE, no done; a fresh start afterwards completes normally.
- RAM_LATENCY=3, SEL_LEAD=2 -> mat_data_in word k at cycle 5+k; selects at cycle 3+k; done at cycle 24; with LOAD_CNT_EN, load_count = 1 after the load.

Source files
------------

// File: rtl/input_mat_loader_pkg.sv
// Shared types and constants for the input-matrix loader.
// Word layout: one RAM word carries four elements of one bank half-row.
package input_mat_loader_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int BANK_DEPTH       = 8;
    localparam int SELECT_WIDTH     = 3;
    localparam int WORD_ELEMS       = 4;
    localparam int WORD_WIDTH       = WORD_ELEMS * DATA_WIDTH;
    localparam int WORDS_PER_MATRIX = (BANK_DEPTH * BANK_DEPTH) / WORD_ELEMS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_e;

    typedef struct packed {
        logic                    valid;
        logic [SELECT_WIDTH-1:0] bank;
        logic                    half;
    } tag_t;

    function automatic tag_t make_tag(logic vld, logic [3:0] k);
        tag_t t;
        t.valid = vld;
        t.bank  = k[3:1];
        t.half  = k[0];
        return t;
    endfunction

endpackage

// File: rtl/input_mat_tag_pipe.sv
// Tag shift register tracking outstanding RAM reads.
// Virtual stage 0 is the incoming tag; registered stages are 1..DEPTH.
module input_mat_tag_pipe
    import input_mat_loader_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int SEL_TAP = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  tag_t tag_i,
    output logic data_vld_o,
    output tag_t sel_tag_o,
    output logic busy_o
);

    tag_t st_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i] <= '0;
            end
        end else begin
            st_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                st_q[i] <= st_q[i-1];
            end
        end
    end

    assign data_vld_o = st_q[DEPTH-1].valid;

    generate
        if (SEL_TAP == 0) begin : g_tap_in
            assign sel_tag_o = tag_i;
        end else begin : g_tap_reg
            assign sel_tag_o = st_q[SEL_TAP-1];
        end
    endgenerate

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_o = busy_o | st_q[i].valid;
        end
    end

endmodule

// File: rtl/input_mat_loader.sv
// Streams one 8x8 matrix from RAM into the input register bank.
// Optional LOAD_CNT_EN adds a 16-bit completed-load counter output.
module input_mat_loader
    import input_mat_loader_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int RAM_LATENCY  = 1,
    parameter int SEL_LEAD     = 2,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    ram_en,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    input  logic [WORD_WIDTH-1:0]   ram_rdata,
    output logic                    mat_enable,
    output logic [SELECT_WIDTH-1:0] mat_bank_sel,
    output logic [SELECT_WIDTH-1:0] mat_sel,
    output logic [WORD_WIDTH-1:0]   mat_data_in
`ifdef LOAD_CNT_EN
    ,
    output logic [15:0]             load_count
`endif
);

    localparam int         DEPTH   = RAM_LATENCY + 1;
    localparam int         SEL_TAP = RAM_LATENCY + 1 - SEL_LEAD;
    localparam logic [3:0] LAST_K  = 4'(WORDS_PER_MATRIX - 1);
    localparam logic [3:0] FC_LAST = 4'(FLUSH_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [3:0]              k_q, k_d;
    logic [3:0]              fc_q, fc_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [WORD_WIDTH-1:0]   data_q;
    logic [SELECT_WIDTH-1:0] bank_q;
    logic                    half_q;

    tag_t tag_in;
    tag_t sel_tag;
    logic data_vld;
    logic pipe_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            fc_q    <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            fc_q    <= fc_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        fc_d    = fc_q;
        base_d  = base_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                k_d = k_q + 4'd1;
                if (k_q == LAST_K) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pipe_busy) begin
                    fc_d    = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                fc_d = fc_q + 4'd1;
                if (fc_q == FC_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Tag is built from next-state so a zero-lead select tap is still registered.
    assign tag_in = make_tag(state_d == S_ISSUE, k_d);

    input_mat_tag_pipe #(
        .DEPTH   (DEPTH),
        .SEL_TAP (SEL_TAP)
    ) u_tag_pipe (
        .clk_i      (clk),
        .rst_i      (reset),
        .tag_i      (tag_in),
        .data_vld_o (data_vld),
        .sel_tag_o  (sel_tag),
        .busy_o     (pipe_busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            bank_q <= '0;
            half_q <= 1'b0;
        end else begin
            if (data_vld) begin
                data_q <= ram_rdata;
            end
            if (sel_tag.valid) begin
                bank_q <= sel_tag.bank;
                half_q <= sel_tag.half;
            end
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign mat_enable   = busy;
    assign done         = (state_q == S_DONE);
    assign ram_en       = (state_q == S_ISSUE);
    assign ram_addr     = ram_en ? base_q + ADDR_WIDTH'(k_q) : '0;
    assign mat_data_in  = data_q;
    assign mat_bank_sel = bank_q;
    assign mat_sel      = {{(SELECT_WIDTH-1){1'b0}}, half_q};

`ifdef LOAD_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == S_DONE) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign load_count = cnt_q;
`endif

endmodule

// File: tb/tb_input_mat_loader.sv
// Bench for input_mat_loader: two instances (RAM_LATENCY 1 and 3) run in lockstep
// against a cycle-level timing model and a downstream register-bank model.
module tb_input_mat_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;

    logic        busy1, done1, en1, mate1;
    logic [9:0]  addr1;
    logic [31:0] rd1, din1;
    logic [2:0]  bsel1, sel1;
    logic        busy3, done3, en3, mate3;
    logic [9:0]  addr3;
    logic [31:0] rd3, din3;
    logic [2:0]  bsel3, sel3;
`ifdef LOAD_CNT_EN
    logic [15:0] lc1, lc3;
`endif

    always #5 clk = ~clk;

    input_mat_loader u1 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy1), .done(done1), .ram_en(en1), .ram_addr(addr1),
        .ram_rdata(rd1), .mat_enable(mate1), .mat_bank_sel(bsel1),
        .mat_sel(sel1), .mat_data_in(din1)
`ifdef LOAD_CNT_EN
        , .load_count(lc1)
`endif
    );

    input_mat_loader #(.RAM_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy3), .done(done3), .ram_en(en3), .ram_addr(addr3),
        .ram_rdata(rd3), .mat_enable(mate3), .mat_bank_sel(bsel3),
        .mat_sel(sel3), .mat_data_in(din3)
`ifdef LOAD_CNT_EN
        , .load_count(lc3)
`endif
    );

    logic [31:0] mem [1024];
    logic [31:0] rp1;
    logic [31:0] rp3 [3];

    always @(posedge clk) begin
        rp1    <= mem[addr1];
        rp3[0] <= mem[addr3];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign rd1 = rp1;
    assign rd3 = rp3[2];

    typedef struct packed {
        logic        busy, done, en, mate;
        logic [9:0]  addr;
        logic [2:0]  bsel, sel;
        logic [31:0] din;
    } obs_t;

    obs_t ob [2];
    always_comb begin
        ob[0] = '{busy1, done1, en1, mate1, addr1, bsel1, sel1, din1};
        ob[1] = '{busy3, done3, en3, mate3, addr3, bsel3, sel3, din3};
    end

    typedef struct {
        logic [9:0] base;
        bit         restart;
        int         rst_at;
        logic [9:0] exp_last;
        int         exp_dones;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cur_c = 0;

    // Model state: held output values and a downstream bank with 2-cycle select delay.
    logic [31:0] hd [2];
    logic [2:0]  hb [2];
    logic        hh [2];
    logic [31:0] bm [2][8][2];
    logic [3:0]  d0 [2];
    logic [3:0]  d1 [2];
    int          lc_exp = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h",
                     nm, i, cur_c, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int          dn [2];
        logic [9:0]  last [2];
        dn   = '{0, 0};
        last = '{10'd0, 10'd0};
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            cur_c = c;
            for (int i = 0; i < 2; i++) begin
                int  L;
                bit  rs;
                bit  e_en, e_busy, e_done;
                L  = (i == 0) ? 1 : 3;
                rs = (v.rst_at >= 0) && (c > v.rst_at);
                e_en   = !rs && c >= 1 && c <= 16;
                e_busy = !rs && c >= 1 && c <= L + 21;
                e_done = !rs && c == L + 21;
                if (rs) begin
                    hd[i] = '0;
                    hb[i] = '0;
                    hh[i] = 1'b0;
                end else begin
                    if (c >= L + 2 && c <= L + 17)
                        hd[i] = mem[(int'(v.base) + c - L - 2) & 1023];
                    if (c >= L && c <= L + 15) begin
                        hb[i] = 3'((c - L) >> 1);
                        hh[i] = 1'((c - L) & 1);
                    end
                end
                chk("ram_en", i, 32'(ob[i].en), 32'(e_en));
                chk("busy", i, 32'(ob[i].busy), 32'(e_busy));
                chk("mat_enable", i, 32'(ob[i].mate), 32'(e_busy));
                chk("done", i, 32'(ob[i].done), 32'(e_done));
                if (e_en)
                    chk("ram_addr", i, 32'(ob[i].addr),
                        32'((int'(v.base) + c - 1) & 1023));
                else if (rs)
                    chk("ram_addr_rst", i, 32'(ob[i].addr), 32'd0);
                chk("mat_data_in", i, ob[i].din, hd[i]);
                chk("mat_bank_sel", i, 32'(ob[i].bsel), 32'(hb[i]));
                chk("mat_sel", i, 32'(ob[i].sel), 32'(hh[i]));
                dn[i] += int'(ob[i].done);
                if (ob[i].en) last[i] = ob[i].addr;
                if (ob[i].mate) begin
                    bm[i][d1[i][3:1]][d1[i][0]] = ob[i].din;
                    d1[i] = d0[i];
                    d0[i] = {ob[i].bsel, ob[i].sel[0]};
                end
            end
            start     = (c == 0) || (v.restart && (c == 5 || c == 22));
            base_addr = (c == 0) ? v.base : ~v.base;
            reset     = (c == v.rst_at);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("done_count", i, 32'(dn[i]), 32'(v.exp_dones));
            chk("last_addr", i, 32'(last[i]), 32'(v.exp_last));
            if (v.rst_at < 0) begin
                for (int b = 0; b < 8; b++)
                    for (int h = 0; h < 2; h++)
                        chk("bank_word", i, bm[i][b][h],
                            mem[(int'(v.base) + 2 * b + h) & 1023]);
            end
        end
        lc_exp = (v.rst_at >= 0) ? 0 : lc_exp + 1;
`ifdef LOAD_CNT_EN
        chk("load_count", 0, 32'(lc1), 32'(lc_exp));
        chk("load_count", 1, 32'(lc3), 32'(lc_exp));
`endif
    endtask

    vec_t vt [5];

    initial begin
        vt[0] = '{10'h040, 1'b0, -1, 10'h04F, 1};
        vt[1] = '{10'h3F8, 1'b0, -1, 10'h007, 1};
        vt[2] = '{10'h040, 1'b1, -1, 10'h04F, 1};
        vt[3] = '{10'h100, 1'b0, 10, 10'h109, 0};
        vt[4] = '{10'h2A0, 1'b0, -1, 10'h2AF, 1};
        for (int n = 0; n < 1024; n++) begin
            logic [7:0] b8;
            b8 = 8'(n);
            mem[n] = {4{b8}};
        end
        for (int i = 0; i < 2; i++) begin
            hd[i] = '0; hb[i] = '0; hh[i] = 1'b0;
            d0[i] = '0; d1[i] = '0;
            for (int b = 0; b < 8; b++) begin
                bm[i][b][0] = '0;
                bm[i][b][1] = '0;
            end
        end
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        repeat (2) @(negedge clk);
        cur_c = -1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, 32'(ob[i].busy), 32'd0);
            chk("rst_done", i, 32'(ob[i].done), 32'd0);
            chk("rst_en", i, 32'({ob[i].en, ob[i].mate}), 32'd0);
            chk("rst_addr", i, 32'(ob[i].addr), 32'd0);
            chk("rst_sel", i, 32'({ob[i].bsel, ob[i].sel}), 32'd0);
            chk("rst_data", i, ob[i].din, 32'd0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int t = 0; t < 5; t++) begin
            run(vt[t]);
            repeat (2) @(negedge clk);
        end
        for (int r = 0; r < 4; r++) begin
            vec_t v;
            for (int n = 0; n < 1024; n++) mem[n] = $urandom;
            v.base      = 10'($urandom_range(0, 1023));
            v.restart   = 1'($urandom_range(0, 1));
            v.rst_at    = -1;
            v.exp_last  = v.base + 10'd15;
            v.exp_dones = 1;
            run(v);
            repeat (3) @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
